// File: rtl/motion_frame_stats.sv
// Per-frame motion statistics: pixel count, bounding box and a debounced alarm.
// Consumes the raster-scan motion mask and reports once per completed frame.
module motion_frame_stats #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int X_W          = 9,
  parameter int Y_W          = 8,
  parameter int CNT_W        = 17,
  parameter int ALARM_FRAMES = 3,
  parameter int CLEAR_FRAMES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic             motion_bit,
  input  logic [CNT_W-1:0] count_thr,
  output logic             frame_done,
  output logic [CNT_W-1:0] motion_count,
  output logic             bbox_valid,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic             alarm,
  output logic             frame_err
);

  localparam int LIM = (ALARM_FRAMES > CLEAR_FRAMES) ? ALARM_FRAMES : CLEAR_FRAMES;
  localparam int S_W = $clog2(LIM + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [S_W-1:0] A_LIM  = S_W'(ALARM_FRAMES);
  localparam logic [S_W-1:0] C_LIM  = S_W'(CLEAR_FRAMES);

  typedef enum logic [1:0] {QUIET, PENDING, ALARM, CLEARING} state_t;

  logic             act_q, act_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [X_W-1:0]   bx0_q, bx0_d, bx1_q, bx1_d;
  logic [Y_W-1:0]   by0_q, by0_d, by1_q, by1_d;
  logic             done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             obv_q, obv_d;
  logic [X_W-1:0]   ox0_q, ox0_d, ox1_q, ox1_d;
  logic [Y_W-1:0]   oy0_q, oy0_d, oy1_q, oy1_d;
  state_t           state_q, state_d;
  logic [S_W-1:0]   streak_q, streak_d, stk_inc;

  logic             take, fin, m;
  logic [X_W-1:0]   px;
  logic [Y_W-1:0]   py;

  // Coordinate tracking, accumulation and result latching at frame end
  always_comb begin
    take = 1'b0;
    fin  = 1'b0;
    px   = x_q;
    py   = y_q;
    act_d = act_q;
    x_d = x_q;
    y_d = y_q;
    cnt_d = cnt_q;
    hit_d = hit_q;
    bx0_d = bx0_q;
    bx1_d = bx1_q;
    by0_d = by0_q;
    by1_d = by1_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    ocnt_d = ocnt_q;
    obv_d  = obv_q;
    ox0_d  = ox0_q;
    ox1_d  = ox1_q;
    oy0_d  = oy0_q;
    oy1_d  = oy1_q;
    if (pix_valid && frame_start) begin
      take  = 1'b1;
      err_d = act_q;
      px    = '0;
      py    = '0;
      cnt_d = '0;
      hit_d = 1'b0;
      bx0_d = '0;
      bx1_d = '0;
      by0_d = '0;
      by1_d = '0;
    end else if (pix_valid && act_q) begin
      take = 1'b1;
      fin  = (x_q == X_LAST) && (y_q == Y_LAST);
    end
    if (take && motion_bit) begin
      if (!(&cnt_d)) cnt_d = cnt_d + CNT_W'(1);
      if (!hit_d) begin
        bx0_d = px;
        bx1_d = px;
        by0_d = py;
        by1_d = py;
      end else begin
        if (px < bx0_d) bx0_d = px;
        if (px > bx1_d) bx1_d = px;
        if (py < by0_d) by0_d = py;
        if (py > by1_d) by1_d = py;
      end
      hit_d = 1'b1;
    end
    if (take) begin
      act_d = 1'b1;
      if (px == X_LAST) begin
        x_d = '0;
        y_d = py + Y_W'(1);
      end else begin
        x_d = px + X_W'(1);
        y_d = py;
      end
    end
    if (fin) begin
      act_d  = 1'b0;
      x_d    = '0;
      y_d    = '0;
      done_d = 1'b1;
      ocnt_d = cnt_d;
      obv_d  = hit_d;
      ox0_d  = hit_d ? bx0_d : '0;
      ox1_d  = hit_d ? bx1_d : '0;
      oy0_d  = hit_d ? by0_d : '0;
      oy1_d  = hit_d ? by1_d : '0;
    end
  end

  // Alarm debounce, stepped once per completed frame
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    stk_inc  = streak_q + S_W'(1);
    m        = (cnt_d >= count_thr);
    if (fin) begin
      unique case (state_q)
        QUIET: begin
          if (m) begin
            if (ALARM_FRAMES == 1) begin
              state_d  = ALARM;
              streak_d = '0;
            end else begin
              state_d  = PENDING;
              streak_d = S_W'(1);
            end
          end
        end
        PENDING: begin
          if (!m) begin
            state_d  = QUIET;
            streak_d = '0;
          end else if (stk_inc == A_LIM) begin
            state_d  = ALARM;
            streak_d = '0;
          end else begin
            streak_d = stk_inc;
          end
        end
        ALARM: begin
          if (m) begin
            streak_d = '0;
          end else if (CLEAR_FRAMES == 1) begin
            state_d  = QUIET;
            streak_d = '0;
          end else begin
            state_d  = CLEARING;
            streak_d = S_W'(1);
          end
        end
        CLEARING: begin
          if (m) begin
            state_d  = ALARM;
            streak_d = '0;
          end else if (stk_inc == C_LIM) begin
            state_d  = QUIET;
            streak_d = '0;
          end else begin
            streak_d = stk_inc;
          end
        end
        default: begin
          state_d  = QUIET;
          streak_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      bx0_q <= '0;
      bx1_q <= '0;
      by0_q <= '0;
      by1_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ocnt_q <= '0;
      obv_q <= 1'b0;
      ox0_q <= '0;
      ox1_q <= '0;
      oy0_q <= '0;
      oy1_q <= '0;
      state_q <= QUIET;
      streak_q <= '0;
    end else begin
      act_q <= act_d;
      x_q <= x_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      bx0_q <= bx0_d;
      bx1_q <= bx1_d;
      by0_q <= by0_d;
      by1_q <= by1_d;
      done_q <= done_d;
      err_q <= err_d;
      ocnt_q <= ocnt_d;
      obv_q <= obv_d;
      ox0_q <= ox0_d;
      ox1_q <= ox1_d;
      oy0_q <= oy0_d;
      oy1_q <= oy1_d;
      state_q <= state_d;
      streak_q <= streak_d;
    end
  end

  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign motion_count = ocnt_q;
  assign bbox_valid   = obv_q;
  assign x_min        = ox0_q;
  assign x_max        = ox1_q;
  assign y_min        = oy0_q;
  assign y_max        = oy1_q;
  assign alarm        = (state_q == ALARM) || (state_q == CLEARING);

endmodule

// File: tb/tb_motion_frame_stats.sv
// Bench for motion_frame_stats on an 8x4 frame.
// Random frames and stalls checked against a frame-level reference model.
module tb_motion_frame_stats;

  localparam int W = 8;
  localparam int H = 4;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int CW = 4;
  localparam int AF = 3;
  localparam int CF = 5;
  localparam int NPIX = W * H;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic pix_valid, frame_start, motion_bit;
  logic [CW-1:0] count_thr;
  logic frame_done, bbox_valid, alarm, frame_err;
  logic [CW-1:0] motion_count;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;

  int n_tests = 0;
  int n_fail = 0;
  bit m_alarm = 1'b0;
  int m_run = 0;

  always #5 clk = ~clk;

  motion_frame_stats #(
    .IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW), .CNT_W(CW),
    .ALARM_FRAMES(AF), .CLEAR_FRAMES(CF)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .frame_start(frame_start), .motion_bit(motion_bit),
    .count_thr(count_thr), .frame_done(frame_done),
    .motion_count(motion_count), .bbox_valid(bbox_valid),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .alarm(alarm), .frame_err(frame_err)
  );

  function automatic logic [15:0] got();
    return {motion_count, bbox_valid, x_min, x_max, y_min, y_max, alarm};
  endfunction

  // Frame result from the list of motion pixels, plus the model alarm
  function automatic logic [15:0] expect_res(input logic [31:0] bits, input bit al);
    int c, x0, x1, y0, y1;
    logic [CW-1:0] cs;
    c = 0; x0 = W; x1 = -1; y0 = H; y1 = -1;
    for (int p = 0; p < NPIX; p++) begin
      if (bits[p]) begin
        c++;
        if (p % W < x0) x0 = p % W;
        if (p % W > x1) x1 = p % W;
        if (p / W < y0) y0 = p / W;
        if (p / W > y1) y1 = p / W;
      end
    end
    cs = (c > CMAX) ? CW'(CMAX) : CW'(c);
    if (c == 0) begin
      x0 = 0; x1 = 0; y0 = 0; y1 = 0;
    end
    return {cs, c > 0, XW'(x0), XW'(x1), YW'(y0), YW'(y1), al};
  endfunction

  // Alarm: rises after AF motion frames in a row, falls after CF quiet ones
  task automatic alarm_step(input logic [31:0] bits);
    int c;
    bit m;
    c = $countones(bits);
    if (c > CMAX) c = CMAX;
    m = (c >= int'(count_thr));
    if (!m_alarm) begin
      m_run = m ? m_run + 1 : 0;
      if (m_run >= AF) begin m_alarm = 1'b1; m_run = 0; end
    end else begin
      m_run = m ? 0 : m_run + 1;
      if (m_run >= CF) begin m_alarm = 1'b0; m_run = 0; end
    end
  endtask

  function automatic logic [31:0] pick(input int k);
    logic [31:0] b;
    b = '0;
    while ($countones(b) < k) b[$urandom_range(NPIX - 1)] = 1'b1;
    return b;
  endfunction

  task automatic send_frame(input logic [31:0] bits, input int stall_pct,
                            output bit err0, output bit done_last,
                            output bit done_next, output int spurious,
                            output logic [15:0] res);
    spurious = 0;
    err0 = 1'b0;
    done_last = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      for (int s = 0; s < 4 && $urandom_range(99) < stall_pct; s++) begin
        pix_valid = 1'b0;
        frame_start = 1'($urandom);
        motion_bit = 1'($urandom);
        @(negedge clk);
        if (frame_done || frame_err) spurious++;
      end
      pix_valid = 1'b1;
      frame_start = (i == 0);
      motion_bit = bits[i];
      @(negedge clk);
      if (i == 0) err0 = frame_err;
      else if (frame_err) spurious++;
      if (i == NPIX - 1) done_last = frame_done;
      else if (frame_done) spurious++;
    end
    res = got();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    motion_bit = 1'b0;
    @(negedge clk);
    done_next = frame_done;
  endtask

  task automatic send_partial(input logic [31:0] bits, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      frame_start = (i == 0);
      motion_bit = bits[i];
      @(negedge clk);
      if (frame_done || frame_err) pulses++;
    end
    pix_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    motion_bit = 1'b0;
    count_thr = '0;
    #2;
    n_tests++;
    if ({frame_done, frame_err, got()} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 0", {frame_done, frame_err, got()});
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < NPIX + 8; i++) begin
      pix_valid = 1'b1;
      motion_bit = 1'b1;
      @(negedge clk);
      if (frame_done || frame_err) pulses++;
    end
    pix_valid = 1'b0;
    n_tests++;
    if (pulses !== 0 || got() !== 16'h0) begin
      n_fail++;
      $display("FAIL ignore_before_sof: pulses %0d res %h expected 0", pulses, got());
    end
  endtask

  task automatic test_frame(input string name, input logic [31:0] bits, input int stall);
    bit e0, dl, dn;
    int sp;
    logic [15:0] res, exp_r;
    alarm_step(bits);
    exp_r = expect_res(bits, m_alarm);
    send_frame(bits, stall, e0, dl, dn, sp, res);
    n_tests++;
    if ({e0, dl, dn} !== 3'b010 || sp !== 0) begin
      n_fail++;
      $display("FAIL %s_pulses: err0/done/next %b spurious %0d expected 010 0",
               name, {e0, dl, dn}, sp);
    end
    n_tests++;
    if (res !== exp_r) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h", name, res, exp_r);
    end
  endtask

  task automatic test_basic();
    count_thr = 4'd1;
    test_frame("single", 32'h1 << 21, 0);
    test_frame("stalls", (32'h1 << 1) | (32'h1 << 30) | (32'h1 << 11), 40);
    test_frame("empty", 32'h0, 20);
    test_frame("full_sat", 32'hFFFF_FFFF, 10);
  endtask

  task automatic test_early_sof();
    logic [31:0] a, b;
    logic [15:0] held, res, exp_r;
    bit e0, dl, dn;
    int sp, pulses;
    a = $urandom;
    b = pick(4);
    held = got();
    send_partial(a, 20, pulses);
    n_tests++;
    if (pulses !== 0 || got() !== held) begin
      n_fail++;
      $display("FAIL early_partial_hold: pulses %0d res %h expected 0 %h", pulses, got(), held);
    end
    alarm_step(b);
    exp_r = expect_res(b, m_alarm);
    send_frame(b, 0, e0, dl, dn, sp, res);
    n_tests++;
    if ({e0, dl, dn} !== 3'b110 || sp !== 0) begin
      n_fail++;
      $display("FAIL early_pulses: err0/done/next %b spurious %0d expected 110 0", {e0, dl, dn}, sp);
    end
    n_tests++;
    if (res !== exp_r) begin
      n_fail++;
      $display("FAIL early_result: got %h expected %h", res, exp_r);
    end
  endtask

  task automatic test_alarm();
    int counts[16] = '{2, 2, 1, 2, 2, 2, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0};
    bit plan[16] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] b;
    logic [15:0] res, exp_r;
    bit e0, dl, dn;
    int sp;
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    m_alarm = 1'b0;
    m_run = 0;
    count_thr = 4'd2;
    for (int f = 0; f < 16; f++) begin
      b = pick(counts[f]);
      alarm_step(b);
      exp_r = expect_res(b, m_alarm);
      send_frame(b, 15, e0, dl, dn, sp, res);
      n_tests++;
      if (res !== exp_r || !dl || dn || sp !== 0) begin
        n_fail++;
        $display("FAIL alarm_frame%0d: got %h done %b expected %h", f, res, dl, exp_r);
      end
      n_tests++;
      if (res[0] !== plan[f]) begin
        n_fail++;
        $display("FAIL alarm_plan%0d: alarm %b expected %b", f, res[0], plan[f]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [15:0] res, exp_r;
    bit e0, dl, dn;
    int sp, dens;
    for (int f = 0; f < 30; f++) begin
      dens = $urandom_range(100);
      for (int p = 0; p < NPIX; p++) b[p] = ($urandom_range(99) < dens);
      count_thr = CW'($urandom_range(CMAX));
      if (f % 7 == 0) count_thr = '0;
      alarm_step(b);
      exp_r = expect_res(b, m_alarm);
      send_frame(b, 25, e0, dl, dn, sp, res);
      n_tests++;
      if (res !== exp_r || {e0, dl, dn} !== 3'b010 || sp !== 0) begin
        n_fail++;
        $display("FAIL random%0d: got %h pulses %b/%0d expected %h", f, res, {e0, dl, dn}, sp, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [31:0] b;
    count_thr = '0;
    for (int f = 0; f < AF; f++) test_frame("to_alarm", $urandom, 0);
    n_tests++;
    if (alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_alarm: alarm %b expected 1", alarm);
    end
    send_partial($urandom, 10, pulses);
    #2;
    rst = 1'b1;
    #1;
    m_alarm = 1'b0;
    m_run = 0;
    n_tests++;
    if ({frame_done, frame_err, got()} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected 0", {frame_done, frame_err, got()});
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < NPIX + 5; i++) begin
      pix_valid = 1'b1;
      motion_bit = 1'b1;
      @(negedge clk);
      if (frame_done || frame_err) pulses++;
    end
    pix_valid = 1'b0;
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL post_reset_ignore: pulses %0d expected 0", pulses);
    end
    count_thr = 4'd3;
    b = pick(3);
    test_frame("after_reset", b, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_early_sof();
    test_alarm();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
